// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl : RISC-V load/store front end for a 1024x32 one-cycle-latency
// block memory (sign/zero extension, SB/SH read-modify-write, fault detection).
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_access_ctrl #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  done,
  output logic                  fault,
  output logic [31:0]           load_data,
  output logic                  mem_enabled,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  write_enable,
  output logic [31:0]           write_data,
  input  logic [31:0]           read_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_CAP  = 2'd2,
    S_WR   = 2'd3
  } state_t;

  localparam logic [2:0] C_F3_B  = 3'b000;
  localparam logic [2:0] C_F3_H  = 3'b001;
  localparam logic [2:0] C_F3_W  = 3'b010;
  localparam logic [2:0] C_F3_BU = 3'b100;
  localparam logic [2:0] C_F3_HU = 3'b101;

  state_t                state_q, state_d;
  logic                  done_q, done_d;
  logic                  fault_q, fault_d;
  logic [31:0]           load_data_q, load_data_d;
  logic                  mem_en_q, mem_en_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic                  we_q, we_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            lane_q, lane_d;
  logic [15:0]           st_data_q, st_data_d;

  logic                  req_illegal;
  logic                  req_misaligned;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [31:0]           load_ext;
  logic [31:0]           merged;

  // Address bits above the memory's word index alias onto the same words.
  logic                  unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

  always_comb begin
    req_illegal    = req_write ? (req_funct3 > C_F3_W)
                               : ((req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110));
    req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  always_comb begin
    rd_byte = read_data[7:0];
    case (lane_q)
      2'd1:    rd_byte = read_data[15:8];
      2'd2:    rd_byte = read_data[23:16];
      2'd3:    rd_byte = read_data[31:24];
      default: rd_byte = read_data[7:0];
    endcase
    rd_half = lane_q[1] ? read_data[31:16] : read_data[15:0];

    case (funct3_q)
      C_F3_B:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      C_F3_H:  load_ext = {{16{rd_half[15]}}, rd_half};
      C_F3_BU: load_ext = {24'h000000, rd_byte};
      C_F3_HU: load_ext = {16'h0000, rd_half};
      default: load_ext = read_data;
    endcase

    // Store lane merge for the write half of SB/SH.
    merged = read_data;
    if (funct3_q == C_F3_B) begin
      case (lane_q)
        2'd1:    merged[15:8]  = st_data_q[7:0];
        2'd2:    merged[23:16] = st_data_q[7:0];
        2'd3:    merged[31:24] = st_data_q[7:0];
        default: merged[7:0]   = st_data_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merged[31:16] = st_data_q;
    end else begin
      merged[15:0] = st_data_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    fault_d     = 1'b0;
    load_data_d = load_data_q;
    mem_en_d    = 1'b0;
    we_d        = 1'b0;
    address_d   = address_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    funct3_d    = funct3_q;
    lane_d      = lane_q;
    st_data_d   = st_data_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_illegal || req_misaligned) begin
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else if (req_write && (req_funct3 == C_F3_W)) begin
            mem_en_d  = 1'b1;
            we_d      = 1'b1;
            address_d = req_addr[ADDR_WIDTH+1:2];
            wdata_d   = req_wdata;
            state_d   = S_WR;
          end else begin
            mem_en_d  = 1'b1;
            address_d = req_addr[ADDR_WIDTH+1:2];
            write_d   = req_write;
            funct3_d  = req_funct3;
            lane_d    = req_addr[1:0];
            st_data_d = req_wdata[15:0];
            state_d   = S_RD;
          end
        end
      end
      S_RD: begin
        state_d = S_CAP;
      end
      S_CAP: begin
        if (write_q) begin
          wdata_d  = merged;
          mem_en_d = 1'b1;
          we_d     = 1'b1;
          state_d  = S_WR;
        end else begin
          load_data_d = load_ext;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_WR: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      load_data_q <= 32'h0;
      mem_en_q    <= 1'b0;
      we_q        <= 1'b0;
      address_q   <= '0;
      wdata_q     <= 32'h0;
      write_q     <= 1'b0;
      funct3_q    <= 3'b000;
      lane_q      <= 2'b00;
      st_data_q   <= 16'h0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      load_data_q <= load_data_d;
      mem_en_q    <= mem_en_d;
      we_q        <= we_d;
      address_q   <= address_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      funct3_q    <= funct3_d;
      lane_q      <= lane_d;
      st_data_q   <= st_data_d;
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign done         = done_q;
  assign fault        = fault_q;
  assign load_data    = load_data_q;
  assign mem_enabled  = mem_en_q;
  assign address      = address_q;
  assign write_enable = we_q;
  assign write_data   = wdata_q;

endmodule

`default_nettype wire

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

CPU-side initiator for the 1024 x 32 block data memory. Converts RISC-V load/store requests (byte address, funct3 size/sign) into the memory's word-wide, single-port, one-cycle-read-latency protocol. Sign/zero-extends loads, implements SB/SH as read-modify-write, and flags misaligned or illegal accesses. Sits between the execute/memory stage and the block memory.

## Interface
- ADDR_WIDTH, 10, memory word-address width (1024 words)
- CLK  in  1  clock, rising edge
- RSTN  in  1  asynchronous active-low reset
- REQ_VALID  in  1  request present
- REQ_READY  out  1  request accepted when VALID & READY
- REQ_WRITE  in  1  1 = store, 0 = load
- REQ_FUNCT3  in  3  RISC-V funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010
- REQ_ADDR  in  32  byte address; word index = REQ_ADDR[11:2]; bits [31:12] ignored (alias)
- REQ_WDATA  in  32  store data, right-aligned
- DONE  out  1  one-cycle pulse, request complete
- FAULT  out  1  valid with DONE: misaligned or illegal funct3, no memory access made
- LOAD_DATA  out  32  extended load result, valid with DONE, held until next load DONE
- MEM_ENABLED  out  1  memory enable
- ADDRESS  out  ADDR_WIDTH  memory word address
- WRITE_ENABLE  out  1  memory write enable
- WRITE_DATA  out  32  memory write data
- READ_DATA  in  32  memory read data, valid the cycle after an enabled read cycle

## Operation
- FSM states: IDLE, RD, CAP, WR. REQ_READY = (state == IDLE).
- All outputs except REQ_READY are registered. Reset value: state IDLE, every output 0, including LOAD_DATA.
- Accept in IDLE:
  - Illegal: load funct3 011/110/111, store funct3 >= 011, halfword with addr[0] = 1, word with addr[1:0] != 0. Next cycle DONE = 1, FAULT = 1. No MEM_ENABLED. LOAD_DATA unchanged. Stay IDLE.
  - Load or SB/SH: MEM_ENABLED <= 1, WRITE_ENABLE <= 0, ADDRESS <= word index. Latch the request. Go to RD.
  - SW: MEM_ENABLED <= 1, WRITE_ENABLE <= 1, WRITE_DATA <= REQ_WDATA. Go to WR.
- RD: MEM_ENABLED <= 0. Go to CAP.
- CAP, READ_DATA valid:
  - Load: select the byte lane (addr[1:0]) or halfword lane (addr[1]). Sign-extend for LB/LH, zero-extend for LBU/LHU; LW passes the word through. LOAD_DATA <= result, DONE <= 1. Go to IDLE.
  - SB/SH: WRITE_DATA <= READ_DATA with the addressed lane replaced by REQ_WDATA[7:0] or [15:0]. MEM_ENABLED <= 1, WRITE_ENABLE <= 1. Go to WR.
- WR: MEM_ENABLED <= 0, WRITE_ENABLE <= 0, DONE <= 1. Go to IDLE.
- DONE and FAULT clear the next cycle.
- Back-to-back: a new request may be accepted in the cycle DONE is high.
- Reset mid-operation: asynchronous return to IDLE with all outputs 0. A pending RMW write is abandoned. Memory contents are left as of the last completed write.
- Request inputs are sampled only at accept. Changes afterward are ignored.

## Timing
- Latency from accept edge to DONE-high cycle (accept in cycle 0):
  - Fault: DONE in cycle 1.
  - SW: DONE in cycle 2.
  - Loads: DONE in cycle 3.
  - SB/SH: DONE in cycle 4.
- MEM_ENABLED is high for exactly one cycle per memory access.
- RMW: the read and the write are on separate, non-adjacent enable cycles.
- Single initiator. No atomicity required beyond no acceptance during RMW.

## Test plan
- Memory word 5 = 0x8899AABB. LB addr 0x15 -> DONE in cycle 3, LOAD_DATA 0xFFFFFFAA, FAULT 0. LBU 0x15 -> 0x000000AA. LHU 0x16 -> 0x00008899. LH 0x16 -> 0xFFFF8899.
- SB addr 0x14, WDATA 0x12345677 -> DONE in cycle 4. Word 5 = 0x8899AA77, exactly one WRITE_ENABLE cycle.
- SH addr 0x16, WDATA 0x0000CAFE -> word 5 = 0xCAFEAABB. SW addr 0x14, WDATA 0xDEADBEEF -> DONE in cycle 2, word 5 = 0xDEADBEEF.
- LW addr 0x16; SH addr 0x15; load funct3 011 -> each gives DONE and FAULT in cycle 1. MEM_ENABLED never rises. LOAD_DATA unchanged.
- Pull RSTN low during RD of an SB -> all outputs 0 immediately, REQ_READY 1, memory word unchanged. Then back-to-back LW 0x00 and LW 0x04, with the second accepted in the first's DONE cycle -> two DONE pulses 3 cycles apart.
